// File: rtl/gmii_tx_pkg.sv
// Shared constants and the CRC-32 byte step for the GMII transmit framer.
// The CRC helper is only used when the build defines GMII_TX_FCS_EN.
package gmii_tx_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PRE   = 3'd1;
   localparam logic [2:0] ST_SFD   = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;
   localparam logic [2:0] ST_PAD   = 3'd5;
   localparam logic [2:0] ST_FCS   = 3'd6;
   localparam logic [2:0] ST_IFG   = 3'd7;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

   // Reflected CRC-32, one byte per call, LSB of the byte first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc ^ {24'h000000, d};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 update for one byte; instantiated by the framer
// only when GMII_TX_FCS_EN is defined.
module crc32_d8
   import gmii_tx_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  d,
   output logic [31:0] crc_out
);

   assign crc_out = crc32_byte(crc_in, d);

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: FWFT FIFO -> preamble/SFD, data, padding, optional FCS
// (macro GMII_TX_FCS_EN), minimum inter-frame gap, underrun signalling on TX_ER.
module gmii_tx_framer
   import gmii_tx_pkg::*;
#(
   parameter int PREAMBLE_LEN = 7,
   parameter int IFG_LEN      = 12,
   parameter int MIN_LEN      = 60
) (
   input  logic       gmii_gtx_clk,
   input  logic       sys_rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_din,
   input  logic       fifo_eof,
   output logic       fifo_rd,
   output logic       gmii_en,
   output logic       gmii_er,
   output logic [7:0] gmii_dout,
   output logic       tx_underrun
);

   localparam logic [7:0]  PRE_LAST  = 8'(PREAMBLE_LEN - 1);
   localparam logic [7:0]  IFG_LAST  = 8'(IFG_LEN - 1);
   localparam logic [16:0] MIN_LEN_W = 17'(MIN_LEN);

   logic [2:0]  state;
   logic [15:0] byte_cnt;
   logic [16:0] byte_cnt_inc;
   logic [15:0] byte_cnt_sat;
   logic [7:0]  cnt;

`ifdef GMII_TX_FCS_EN
   localparam logic [2:0] END_STATE = ST_FCS;
   logic [31:0] crc;
   logic [31:0] crc_next;
   logic [31:0] fcs_word;
   logic [7:0]  crc_byte;
   logic [1:0]  fcs_idx;

   assign crc_byte = (state == ST_PAD) ? 8'h00 : fifo_din;
   assign fcs_word = ~crc;

   crc32_d8 u_crc32 (
      .crc_in  (crc),
      .d       (crc_byte),
      .crc_out (crc_next)
   );
`else
   localparam logic [2:0] END_STATE = ST_IFG;
`endif

   assign fifo_rd      = ((state == ST_DATA) || (state == ST_DRAIN)) && !fifo_empty;
   assign byte_cnt_inc = {1'b0, byte_cnt} + 17'd1;
   assign byte_cnt_sat = (&byte_cnt) ? byte_cnt : byte_cnt_inc[15:0];

   // Outputs are a registered function of the state in the previous cycle,
   // so every byte appears one clock after the state that produced it.
   always_ff @(posedge gmii_gtx_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state       <= ST_IDLE;
         byte_cnt    <= 16'h0000;
         cnt         <= 8'h00;
         gmii_en     <= 1'b0;
         gmii_er     <= 1'b0;
         gmii_dout   <= 8'h00;
         tx_underrun <= 1'b0;
`ifdef GMII_TX_FCS_EN
         crc         <= 32'h00000000;
         fcs_idx     <= 2'd0;
`endif
      end else begin
         gmii_en     <= 1'b0;
         gmii_er     <= 1'b0;
         gmii_dout   <= 8'h00;
         tx_underrun <= 1'b0;
         case (state)
            ST_IDLE: begin
               cnt <= 8'h00;
               if (!fifo_empty) state <= ST_PRE;
            end
            ST_PRE: begin
               gmii_en   <= 1'b1;
               gmii_dout <= PREAMBLE_BYTE;
               if (cnt == PRE_LAST) begin
                  cnt   <= 8'h00;
                  state <= ST_SFD;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_SFD: begin
               gmii_en   <= 1'b1;
               gmii_dout <= SFD_BYTE;
               byte_cnt  <= 16'h0000;
`ifdef GMII_TX_FCS_EN
               crc       <= CRC_INIT;
               fcs_idx   <= 2'd0;
`endif
               state     <= ST_DATA;
            end
            ST_DATA: begin
               gmii_en <= 1'b1;
               if (!fifo_empty) begin
                  gmii_dout <= fifo_din;
                  byte_cnt  <= byte_cnt_sat;
`ifdef GMII_TX_FCS_EN
                  crc       <= crc_next;
`endif
                  if (fifo_eof) state <= (byte_cnt_inc < MIN_LEN_W) ? ST_PAD : END_STATE;
               end else begin
                  gmii_er     <= 1'b1;
                  tx_underrun <= 1'b1;
                  state       <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!fifo_empty && fifo_eof) state <= ST_IFG;
            end
            ST_PAD: begin
               gmii_en  <= 1'b1;
               byte_cnt <= byte_cnt_sat;
`ifdef GMII_TX_FCS_EN
               crc      <= crc_next;
`endif
               if (byte_cnt_inc >= MIN_LEN_W) state <= END_STATE;
            end
`ifdef GMII_TX_FCS_EN
            ST_FCS: begin
               gmii_en   <= 1'b1;
               gmii_dout <= fcs_word[8*fcs_idx +: 8];
               fcs_idx   <= fcs_idx + 2'd1;
               if (fcs_idx == 2'd3) state <= ST_IFG;
            end
`endif
            // Leaving straight for PRE keeps the low time at exactly IFG_LEN cycles.
            ST_IFG: begin
               if (cnt == IFG_LAST) begin
                  cnt   <= 8'h00;
                  state <= fifo_empty ? ST_IDLE : ST_PRE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Scoreboard bench for gmii_tx_framer: two instances (7/12/60 and 1/1/0),
// FIFO models, expected-byte queues and per-instance monitors.
module tb_gmii_tx_framer;

   typedef struct packed {
      logic [15:0] gap;
      logic        er;
      logic [7:0]  b;
   } exp_t;

   logic       gmii_gtx_clk = 1'b0;
   logic       rst_a = 1'b0;
   logic       rst_b = 1'b0;
   logic       fifo_empty_a = 1'b1;
   logic       fifo_eof_a   = 1'b0;
   logic [7:0] fifo_din_a   = 8'h00;
   logic       fifo_empty_b = 1'b1;
   logic       fifo_eof_b   = 1'b0;
   logic [7:0] fifo_din_b   = 8'h00;
   logic       fifo_rd_a, gmii_en_a, gmii_er_a, tx_underrun_a;
   logic       fifo_rd_b, gmii_en_b, gmii_er_b, tx_underrun_b;
   logic [7:0] gmii_dout_a, gmii_dout_b;

   int checks   = 0;
   int failures = 0;

   logic [9:0] fq_a[$];
   logic [9:0] fq_b[$];
   exp_t       eq_a[$];
   exp_t       eq_b[$];
   logic       rdq_a = 1'b0;
   logic       rdq_b = 1'b0;
   int         low_a = 0;
   int         low_b = 0;

   always #4 gmii_gtx_clk = ~gmii_gtx_clk;

   gmii_tx_framer #(.PREAMBLE_LEN(7), .IFG_LEN(12), .MIN_LEN(60)) dut_a (
      .gmii_gtx_clk (gmii_gtx_clk),
      .sys_rst      (rst_a),
      .fifo_empty   (fifo_empty_a),
      .fifo_din     (fifo_din_a),
      .fifo_eof     (fifo_eof_a),
      .fifo_rd      (fifo_rd_a),
      .gmii_en      (gmii_en_a),
      .gmii_er      (gmii_er_a),
      .gmii_dout    (gmii_dout_a),
      .tx_underrun  (tx_underrun_a)
   );

   gmii_tx_framer #(.PREAMBLE_LEN(1), .IFG_LEN(1), .MIN_LEN(0)) dut_b (
      .gmii_gtx_clk (gmii_gtx_clk),
      .sys_rst      (rst_b),
      .fifo_empty   (fifo_empty_b),
      .fifo_din     (fifo_din_b),
      .fifo_eof     (fifo_eof_b),
      .fifo_rd      (fifo_rd_b),
      .gmii_en      (gmii_en_b),
      .gmii_er      (gmii_er_b),
      .gmii_dout    (gmii_dout_b),
      .tx_underrun  (tx_underrun_b)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

`ifdef GMII_TX_FCS_EN
   function automatic logic [31:0] crcStep(input logic [31:0] crc_in, input logic [7:0] d);
      logic [31:0] c;
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
         else             c = c >> 1;
      end
      return c;
   endfunction
`endif

   task automatic pushFifo(input bit sel, input logic [7:0] d, input logic eof, input logic stall);
      if (sel) fq_b.push_back({stall, eof, d});
      else     fq_a.push_back({stall, eof, d});
   endtask

   task automatic pushExp(input bit sel, input int gap, input logic er, input logic [7:0] b);
      exp_t e;
      e.gap = 16'(gap);
      e.er  = er;
      e.b   = b;
      if (sel) eq_b.push_back(e);
      else     eq_a.push_back(e);
   endtask

   // Queue one frame of n bytes (seed, seed+1, ...) and the GMII bytes it should produce.
   // stall_at >= 0 hides the FIFO for one cycle before that byte; shown < n truncates expectations.
   task automatic applyStimulus(input bit sel, input int n, input logic [7:0] seed,
                                input int gap, input int stall_at, input int shown);
      logic [7:0] fb[$];
      logic [7:0] d;
      int         pre;
      int         minl;
      pre  = sel ? 1 : 7;
      minl = sel ? 0 : 60;
      for (int i = 0; i < pre; i++) pushExp(sel, (i == 0) ? gap : 0, 1'b0, 8'h55);
      pushExp(sel, 0, 1'b0, 8'hD5);
      for (int i = 0; i < n; i++) begin
         d = seed + 8'(i);
         pushFifo(sel, d, (i == n - 1), (i == stall_at));
         if ((stall_at < 0 || i < stall_at) && i < shown) fb.push_back(d);
      end
      if (stall_at < 0 && shown >= n) begin
         while (fb.size() < minl) fb.push_back(8'h00);
      end
      foreach (fb[i]) pushExp(sel, 0, 1'b0, fb[i]);
      if (stall_at >= 0) pushExp(sel, 0, 1'b1, 8'h00);
`ifdef GMII_TX_FCS_EN
      if (stall_at < 0 && shown >= n) begin
         logic [31:0] crc;
         logic [31:0] fcs;
         crc = 32'hFFFFFFFF;
         foreach (fb[i]) crc = crcStep(crc, fb[i]);
         fcs = ~crc;
         for (int k = 0; k < 4; k++) pushExp(sel, 0, 1'b0, fcs[8*k +: 8]);
      end
`endif
   endtask

   task automatic waitDone(input bit sel, input bit need_fifo, input int budget, input string name);
      for (int c = 0; c < budget; c++) begin
         @(negedge gmii_gtx_clk);
         #1;
         if (sel  && eq_b.size() == 0 && (!need_fifo || fq_b.size() == 0)) return;
         if (!sel && eq_a.size() == 0 && (!need_fifo || fq_a.size() == 0)) return;
      end
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout actual=pending required=drained", name);
   endtask

   // FIFO models: pop what the DUT requested on the last edge, then present the new head.
   always @(posedge gmii_gtx_clk) begin
      #1;
      if (rdq_a && !rst_a && fq_a.size() > 0) void'(fq_a.pop_front());
      if (fq_a.size() == 0) begin
         fifo_empty_a = 1'b1;
         fifo_din_a   = 8'h00;
         fifo_eof_a   = 1'b0;
      end else begin
         fifo_din_a   = fq_a[0][7:0];
         fifo_eof_a   = fq_a[0][8];
         fifo_empty_a = fq_a[0][9];
         if (fq_a[0][9]) fq_a[0] = {1'b0, fq_a[0][8:0]};
      end
   end

   always @(posedge gmii_gtx_clk) begin
      #1;
      if (rdq_b && !rst_b && fq_b.size() > 0) void'(fq_b.pop_front());
      if (fq_b.size() == 0) begin
         fifo_empty_b = 1'b1;
         fifo_din_b   = 8'h00;
         fifo_eof_b   = 1'b0;
      end else begin
         fifo_din_b   = fq_b[0][7:0];
         fifo_eof_b   = fq_b[0][8];
         fifo_empty_b = fq_b[0][9];
         if (fq_b[0][9]) fq_b[0] = {1'b0, fq_b[0][8:0]};
      end
   end

   always @(negedge gmii_gtx_clk) begin : mon_a
      exp_t e;
      rdq_a = fifo_rd_a;
      if (fifo_rd_a) checkOutput("a_rd_while_empty", 32'(fifo_empty_a), 32'h0);
      if (gmii_en_a) begin
         if (eq_a.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL a_unexpected_byte actual=%h required=no_byte", gmii_dout_a);
         end else begin
            e = eq_a.pop_front();
            if (e.gap != 16'd0) checkOutput("a_gap", 32'(low_a), 32'(e.gap));
            checkOutput("a_byte", 32'({gmii_er_a, tx_underrun_a, gmii_dout_a}), 32'({e.er, e.er, e.b}));
         end
         low_a = 0;
      end else begin
         low_a++;
         checkOutput("a_idle", 32'({gmii_er_a, tx_underrun_a, gmii_dout_a}), 32'h0);
      end
   end

   always @(negedge gmii_gtx_clk) begin : mon_b
      exp_t e;
      rdq_b = fifo_rd_b;
      if (fifo_rd_b) checkOutput("b_rd_while_empty", 32'(fifo_empty_b), 32'h0);
      if (gmii_en_b) begin
         if (eq_b.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL b_unexpected_byte actual=%h required=no_byte", gmii_dout_b);
         end else begin
            e = eq_b.pop_front();
            if (e.gap != 16'd0) checkOutput("b_gap", 32'(low_b), 32'(e.gap));
            checkOutput("b_byte", 32'({gmii_er_b, tx_underrun_b, gmii_dout_b}), 32'({e.er, e.er, e.b}));
         end
         low_b = 0;
      end else begin
         low_b++;
         checkOutput("b_idle", 32'({gmii_er_b, tx_underrun_b, gmii_dout_b}), 32'h0);
      end
   end

   initial begin
      logic [9:0] ent;
      #1;
      rst_a = 1'b1;
      rst_b = 1'b1;
      #2;
      checkOutput("a_reset_state", 32'({gmii_en_a, gmii_er_a, tx_underrun_a, fifo_rd_a, gmii_dout_a}), 32'h0);
      checkOutput("b_reset_state", 32'({gmii_en_b, gmii_er_b, tx_underrun_b, fifo_rd_b, gmii_dout_b}), 32'h0);
      repeat (3) @(negedge gmii_gtx_clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (2) @(negedge gmii_gtx_clk);
      #1;

      $display("[TB] frame 123456789, no padding");
      for (int i = 0; i < 9; i++) pushFifo(1'b1, 8'h31 + 8'(i), (i == 8), 1'b0);
      pushExp(1'b1, 0, 1'b0, 8'h55);
      pushExp(1'b1, 0, 1'b0, 8'hD5);
      for (int i = 0; i < 9; i++) pushExp(1'b1, 0, 1'b0, 8'h31 + 8'(i));
`ifdef GMII_TX_FCS_EN
      pushExp(1'b1, 0, 1'b0, 8'h26);
      pushExp(1'b1, 0, 1'b0, 8'h39);
      pushExp(1'b1, 0, 1'b0, 8'hF4);
      pushExp(1'b1, 0, 1'b0, 8'hCB);
`endif
      waitDone(1'b1, 1'b1, 200, "t1_check_frame");

      $display("[TB] one-byte preamble, one-cycle gap, back-to-back");
      applyStimulus(1'b1, 5, 8'h10, 0, -1, 5);
      applyStimulus(1'b1, 1, 8'hC0, 1, -1, 1);
      applyStimulus(1'b1, 3, 8'hE0, 1, -1, 3);
      waitDone(1'b1, 1'b1, 200, "t6_short_gap");

      $display("[TB] short frame padded to minimum length");
      applyStimulus(1'b0, 10, 8'hA0, 0, -1, 10);
      waitDone(1'b0, 1'b1, 300, "t2_pad");

      $display("[TB] two preloaded 64-byte frames");
      applyStimulus(1'b0, 64, 8'h00, 0, -1, 64);
      applyStimulus(1'b0, 64, 8'h40, 12, -1, 64);
      waitDone(1'b0, 1'b1, 600, "t3_back_to_back");

      $display("[TB] underrun after byte 20 of 100");
      applyStimulus(1'b0, 100, 8'h20, 0, 20, 100);
      applyStimulus(1'b0, 64, 8'h90, 92, -1, 64);
      waitDone(1'b0, 1'b1, 800, "t4_underrun");

      $display("[TB] reset during data byte 30");
      applyStimulus(1'b0, 40, 8'h60, 0, -1, 30);
      waitDone(1'b0, 1'b0, 300, "t5_reach_byte30");
      rst_a = 1'b1;
      #1;
      checkOutput("a_reset_midframe", 32'({gmii_en_a, gmii_er_a, tx_underrun_a, fifo_rd_a, gmii_dout_a}), 32'h0);
      while (fq_a.size() > 0) begin
         ent = fq_a.pop_front();
         if (ent[8]) break;
      end
      repeat (3) @(negedge gmii_gtx_clk);
      rst_a = 1'b0;
      #1;
      applyStimulus(1'b0, 64, 8'hB0, 0, -1, 64);
      waitDone(1'b0, 1'b1, 400, "t5_after_reset");

      repeat (20) @(negedge gmii_gtx_clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
